// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: parses 8-byte frames from the UART RX FIFO,
// drives host-select / reset / power controls and returns an ACK/NAK frame.
module cmd_frame_ctrl #(
  parameter int FIFO_CNT_W     = 5,
  parameter int TF_DEPTH       = 16,
  parameter int NUM_CH         = 2,
  parameter int CH_W           = 1,
  parameter int POP_GAP        = 3,
  parameter int RESET_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] DEV_ADDR = 8'hAB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rdr,
  input  logic [FIFO_CNT_W-1:0] rf_counter,
  output logic                  rf_pop,
  input  logic [FIFO_CNT_W-1:0] tf_counter,
  output logic [7:0]            tdr,
  output logic                  tf_push,
  input  logic [CH_W-1:0]       cur_host,
  output logic [CH_W-1:0]       host_sel,
  output logic                  force_swi,
  output logic [NUM_CH-1:0]     reset_out,
  output logic [NUM_CH-1:0]     power_on,
  output logic                  err_pulse,
  output logic [7:0]            err_count
);

  localparam int GW = $clog2(POP_GAP + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [4:0] NCH = 5'(NUM_CH);

  typedef enum logic [2:0] {
    IDLE, HUNT0, HUNT1, COLLECT, CHECK, EXEC, REPLY
  } state_t;

  state_t          state;
  logic [GW-1:0]   gap;
  logic [TW-1:0]   to_cnt;
  logic [2:0]      bcnt;
  logic [7:0]      fb [6];
  logic [7:0]      status;
  logic [RW-1:0]   rcnt [NUM_CH];

  logic            take;
  logic            tx_ok;
  logic [3:0]      op;
  logic [3:0]      ch;
  logic            ch_ok;
  logic            is_host;
  logic [NUM_CH-1:0] ch_oh;
  logic [NUM_CH-1:0] trig;
  logic [7:0]      ex_status;
  logic            ex_err;
  logic [7:0]      sum;
  logic [7:0]      rchk;
  logic [7:0]      rbyte;

  assign take    = (gap == '0) && (rf_counter != '0);
  assign tx_ok   = (gap == '0) && (tf_counter < FIFO_CNT_W'(TF_DEPTH));
  assign op      = fb[2][7:4];
  assign ch      = fb[2][3:0];
  assign ch_ok   = {1'b0, ch} < NCH;
  assign is_host = ch == 4'(cur_host);
  assign ch_oh   = NUM_CH'(1) << ch;
  assign sum     = fb[0] + fb[1] + fb[2] + fb[3];
  assign rchk    = 8'h00 - fb[0] - fb[1] - status;

  always_comb begin
    ex_status = 8'h03;
    ex_err    = 1'b0;
    unique case (1'b1)
      !ch_ok: begin
        ex_status = 8'h04;
        ex_err    = 1'b1;
      end
      ch_ok && op == 4'h1: ex_status = 8'h00;
      ch_ok && op == 4'h2: ex_status = is_host ? 8'h01 : 8'h00;
      ch_ok && op == 4'h3: ex_status = 8'h00;
      ch_ok && op == 4'h4: ex_status = is_host ? 8'h01 : 8'h00;
      ch_ok && op == 4'h5: ex_status = 8'h00;
      default: ex_status = 8'h03;
    endcase
  end

  always_comb begin
    trig = '0;
    if (state == EXEC && ch_ok) begin
      if (op == 4'h2 && !is_host) trig = ch_oh;
      if (op == 4'h5) trig = '1;
    end
  end

  always_comb begin
    rbyte = 8'h00;
    unique case (bcnt)
      3'd0: rbyte = 8'hEB;
      3'd1: rbyte = 8'h90;
      3'd2: rbyte = fb[0];
      3'd3: rbyte = fb[1];
      3'd4: rbyte = status;
      3'd5: rbyte = rchk;
      3'd6: rbyte = 8'h09;
      3'd7: rbyte = 8'hD7;
      default: rbyte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf_pop    <= 1'b0;
      tf_push   <= 1'b0;
      tdr       <= 8'h00;
      force_swi <= 1'b0;
      err_pulse <= 1'b0;
      host_sel  <= '0;
      power_on  <= '1;
      gap       <= '0;
      to_cnt    <= '0;
      bcnt      <= '0;
      status    <= 8'h00;
      for (int i = 0; i < 6; i++) fb[i] <= 8'h00;
    end else begin
      rf_pop    <= 1'b0;
      tf_push   <= 1'b0;
      force_swi <= 1'b0;
      err_pulse <= 1'b0;
      if (gap != '0) gap <= gap - 1'b1;
      unique case (state)
        IDLE: if (rf_counter != '0) state <= HUNT0;
        HUNT0: if (take) begin
          rf_pop <= 1'b1;
          gap    <= GW'(POP_GAP + 1);
          if (rdr == 8'hEB) state <= HUNT1;
          else begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end
        end
        HUNT1: if (take) begin
          rf_pop <= 1'b1;
          gap    <= GW'(POP_GAP + 1);
          if (rdr == 8'h90) begin
            state  <= COLLECT;
            bcnt   <= '0;
            to_cnt <= '0;
          end else if (rdr != 8'hEB) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end
        end
        COLLECT: begin
          if (take) begin
            rf_pop   <= 1'b1;
            gap      <= GW'(POP_GAP + 1);
            fb[bcnt] <= rdr;
            to_cnt   <= '0;
            if (bcnt == 3'd5) state <= CHECK;
            else bcnt <= bcnt + 3'd1;
          end else if (rf_counter == '0) begin
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              err_pulse <= 1'b1;
              to_cnt    <= '0;
              state     <= IDLE;
            end else to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          bcnt <= '0;
          if (fb[4] != 8'h09 || fb[5] != 8'hD7) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else if (fb[1] != DEV_ADDR) begin
            state <= IDLE;
          end else if (sum != 8'h00) begin
            err_pulse <= 1'b1;
            status    <= 8'h02;
            state     <= REPLY;
          end else state <= EXEC;
        end
        EXEC: begin
          status    <= ex_status;
          err_pulse <= ex_err;
          state     <= REPLY;
          if (ch_ok) begin
            if (op == 4'h1 || op == 4'h5) begin
              host_sel  <= ch[CH_W-1:0];
              force_swi <= 1'b1;
            end
            if (op == 4'h3) power_on <= power_on | ch_oh;
            if (op == 4'h4 && !is_host) power_on <= power_on & ~ch_oh;
          end
        end
        REPLY: if (tx_ok) begin
          tdr     <= rbyte;
          tf_push <= 1'b1;
          gap     <= GW'(POP_GAP + 1);
          if (bcnt == 3'd7) state <= IDLE;
          else bcnt <= bcnt + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A retrigger reloads the count while the output stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset_out <= '0;
      for (int i = 0; i < NUM_CH; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (trig[i]) begin
          rcnt[i]      <= RW'(RESET_CYCLES - 1);
          reset_out[i] <= 1'b1;
        end else if (rcnt[i] != '0) begin
          rcnt[i] <= rcnt[i] - 1'b1;
        end else begin
          reset_out[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= 8'h00;
    else if (err_pulse && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end

endmodule
